// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared state encodings, grant codes and constants for the
//               fetch/data memory-port arbiter.
// Contents    : arb_state_e  - 2-bit arbiter FSM state
//               GNT_IF/GNT_D - round-robin grant identifiers
//               DEADBEEF     - read data returned on a memory timeout
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GNT_IF = 2'd1,
    ARB_GNT_D  = 2'd2,
    ARB_RESP   = 2'd3
  } arb_state_e;

  localparam logic GNT_IF = 1'b0;
  localparam logic GNT_D  = 1'b1;

  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

endpackage : mem_port_arbiter_pkg

`default_nettype wire

// File: rtl/mem_port_arbiter_timeout_cnt.sv
// ============================================================================
// Module      : arb_timeout_cnt
// Description : Wait counter for an outstanding memory request. Counts the
//               enabled cycles since the last clear and flags the cycle in
//               which the count would reach the limit.
// Ports       : clk       in  system clock
//               reset     in  synchronous, active-low reset
//               clear_i   in  return the count to zero
//               enable_i  in  one more cycle waited without completion
//               limit_i   in  number of waited cycles that ends the wait
//               expired_o out high in the waited cycle that hits the limit
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module arb_timeout_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             expired_o
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      cnt_q <= cnt_q + C_ONE;
    end
  end

  // Flags the waited cycle whose increment reaches the limit, so the
  // requester sees exactly limit_i cycles of outstanding request.
  assign expired_o = enable_i && ((cnt_q + C_ONE) == limit_i);

endmodule : arb_timeout_cnt

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between the CPU fetch port
//               and data port. Each access is a req/ack transaction; the
//               memory-side request is registered and held until mem_ack.
//               Simultaneous requests are granted round-robin.
// Ports       : clk, reset (sync, active-low)
//               if_req/if_addr -> if_rdata/if_ack     fetch port (read only)
//               d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack   data port
//               mem_req/mem_we/mem_addr/mem_wdata <- mem_rdata/mem_ack
//               busy         transaction in flight
//               timeout_err  sticky timeout flag (ARB_TIMEOUT_EN only)
// Config      : `define ARB_TIMEOUT_EN to bound the wait for mem_ack to
//               TIMEOUT cycles; an expired wait completes with 0xDEADBEEF.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic              timeout_err
`endif
);

  arb_state_e        state_q;
  logic              last_gnt_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_ack_q;
  logic              d_ack_q;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic in_gnt;
  logic timeout_expired;
  logic timeout_err_q;

  assign in_gnt = (state_q == ARB_GNT_IF) || (state_q == ARB_GNT_D);

  // Held clear throughout IDLE, so every grant starts counting from zero.
  arb_timeout_cnt #(
    .CNT_W(CNT_W)
  ) u_timeout_cnt (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (state_q == ARB_IDLE),
    .enable_i (in_gnt && !mem_ack),
    .limit_i  (CNT_W'(TIMEOUT)),
    .expired_o(timeout_expired)
  );

  assign timeout_err = timeout_err_q;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ARB_IDLE;
      last_gnt_q  <= GNT_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ARB_IDLE: begin
          // Data wins when it is alone or when fetch had the last grant.
          if (d_req && (!if_req || (last_gnt_q == GNT_IF))) begin
            state_q     <= ARB_GNT_D;
            last_gnt_q  <= GNT_D;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
          end else if (if_req) begin
            state_q     <= ARB_GNT_IF;
            last_gnt_q  <= GNT_IF;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
          end
        end

        ARB_GNT_IF, ARB_GNT_D: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            state_q   <= ARB_RESP;
            if (state_q == ARB_GNT_D) begin
              // A completed write returns zero, not whatever is on the bus.
              d_rdata_q <= mem_we_q ? '0 : mem_rdata;
              d_ack_q   <= 1'b1;
            end else begin
              if_rdata_q <= mem_rdata;
              if_ack_q   <= 1'b1;
            end
          end
`ifdef ARB_TIMEOUT_EN
          else if (timeout_expired) begin
            mem_req_q     <= 1'b0;
            state_q       <= ARB_RESP;
            timeout_err_q <= 1'b1;
            if (state_q == ARB_GNT_D) begin
              d_rdata_q <= DATA_W'(DEADBEEF);
              d_ack_q   <= 1'b1;
            end else begin
              if_rdata_q <= DATA_W'(DEADBEEF);
              if_ack_q   <= 1'b1;
            end
          end
`endif
        end

        ARB_RESP: begin
          // Requests are ignored here, guaranteeing an IDLE cycle between grants.
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          state_q  <= ARB_IDLE;
        end

        default: begin
          state_q <= ARB_IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_rdata   = d_rdata_q;
  assign d_ack     = d_ack_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != ARB_IDLE);

endmodule : mem_port_arbiter

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. Transactions come
//               from a table of hand-computed records; reset, stray ack and
//               timeout behaviour are exercised by short directed sequences.
// Config      : ARB_TIMEOUT_EN adds a second instance with TIMEOUT=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_req, mem_we, busy;

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Expected held rdata per port, updated from the table as acks happen.
  logic [31:0] exp_if_rd;
  logic [31:0] exp_d_rd;

`ifdef ARB_TIMEOUT_EN
  logic timeout_err;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(255)) u_dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .busy(busy)
`ifdef ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

`ifdef ARB_TIMEOUT_EN
  logic        t_d_req, t_mem_ack;
  logic [31:0] t_d_addr, t_if_rdata, t_d_rdata, t_mem_addr, t_mem_wdata;
  logic        t_if_ack, t_d_ack, t_mem_req, t_mem_we, t_busy, t_timeout_err;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4)) u_dut_to (
    .clk(clk), .reset(reset),
    .if_req(1'b0), .if_addr(32'h0), .if_rdata(t_if_rdata), .if_ack(t_if_ack),
    .d_req(t_d_req), .d_we(1'b0), .d_addr(t_d_addr), .d_wdata(32'h0),
    .d_rdata(t_d_rdata), .d_ack(t_d_ack),
    .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
    .mem_rdata(32'h5555_5555), .mem_ack(t_mem_ack), .busy(t_busy),
    .timeout_err(t_timeout_err)
  );
`endif

  typedef struct {
    logic        if_req;
    logic        d_req;
    logic        d_we;
    logic [31:0] if_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    int          delay;      // GNT cycles with mem_ack low before the ack
    logic [31:0] mem_rdata;
    logic        exp_d;      // 1 = data port expected to win the grant
    logic [31:0] exp_addr;
    logic        exp_we;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Entered and left at a negedge with the arbiter in IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    chk($sformatf("v%0d idle busy", idx), {31'd0, busy}, 32'd0);
    if_req  = v.if_req;  d_req  = v.d_req;  d_we = v.d_we;
    if_addr = v.if_addr; d_addr = v.d_addr; d_wdata = v.d_wdata;
    @(negedge clk);
    chk($sformatf("v%0d grant mem_req", idx), {31'd0, mem_req}, 32'd1);
    chk($sformatf("v%0d grant mem_addr", idx), mem_addr, v.exp_addr);
    chk($sformatf("v%0d grant mem_we", idx), {31'd0, mem_we}, {31'd0, v.exp_we});
    chk($sformatf("v%0d grant mem_wdata", idx), mem_wdata, v.exp_wdata);
    chk($sformatf("v%0d grant busy", idx), {31'd0, busy}, 32'd1);
    for (int c = 0; c < v.delay; c++) begin
      // Requester-side inputs move freely; the memory side must not.
      if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_we = ~d_we;
      mem_rdata = $urandom;
      @(negedge clk);
      chk($sformatf("v%0d hold%0d mem_req", idx, c), {31'd0, mem_req}, 32'd1);
      chk($sformatf("v%0d hold%0d mem_addr", idx, c), mem_addr, v.exp_addr);
      chk($sformatf("v%0d hold%0d mem_we", idx, c), {31'd0, mem_we}, {31'd0, v.exp_we});
      chk($sformatf("v%0d hold%0d mem_wdata", idx, c), mem_wdata, v.exp_wdata);
      chk($sformatf("v%0d hold%0d acks", idx, c), {30'd0, if_ack, d_ack}, 32'd0);
    end
    mem_ack = 1'b1; mem_rdata = v.mem_rdata;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    if (v.exp_d) begin
      exp_d_rd = v.exp_rdata; d_req = 1'b0;
    end else begin
      exp_if_rd = v.exp_rdata; if_req = 1'b0;
    end
    chk($sformatf("v%0d resp mem_req", idx), {31'd0, mem_req}, 32'd0);
    chk($sformatf("v%0d resp if_ack", idx), {31'd0, if_ack}, {31'd0, ~v.exp_d});
    chk($sformatf("v%0d resp d_ack", idx), {31'd0, d_ack}, {31'd0, v.exp_d});
    chk($sformatf("v%0d resp if_rdata", idx), if_rdata, exp_if_rd);
    chk($sformatf("v%0d resp d_rdata", idx), d_rdata, exp_d_rd);
    @(negedge clk);
    chk($sformatf("v%0d after acks", idx), {30'd0, if_ack, d_ack}, 32'd0);
    chk($sformatf("v%0d after busy", idx), {31'd0, busy}, 32'd0);
    chk($sformatf("v%0d after if_rdata", idx), if_rdata, exp_if_rd);
    chk($sformatf("v%0d after d_rdata", idx), d_rdata, exp_d_rd);
  endtask

  initial begin
    // Three contended requests (D, IF, D from reset), then single-port traffic.
    //              ifr   dr    we    if_addr       d_addr        d_wdata        dly mem_rdata      D     exp_addr      we    exp_wdata      exp_rdata
    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0300, 32'h0000_0000, 2, 32'h1111_0000, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0000, 32'h1111_0000};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0304, 32'h0000_0000, 0, 32'h2222_0000, 1'b0, 32'h0000_0040, 1'b0, 32'h0000_0000, 32'h2222_0000};
    vecs[2] = '{1'b1, 1'b1, 1'b1, 32'h0000_0044, 32'h0000_0308, 32'h0BAD_F00D, 1, 32'h3333_0000, 1'b1, 32'h0000_0308, 1'b1, 32'h0BAD_F00D, 32'h0000_0000};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0010, 32'h0000_0000, 32'h0000_0000, 1, 32'hCAFE_0001, 1'b0, 32'h0000_0010, 1'b0, 32'h0000_0000, 32'hCAFE_0001};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h0000_0100, 32'h1234_5678, 5, 32'hFFFF_FFFF, 1'b1, 32'h0000_0100, 1'b1, 32'h1234_5678, 32'h0000_0000};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_0000, 32'h0000_0200, 32'h0000_0000, 0, 32'hA5A5_0002, 1'b1, 32'h0000_0200, 1'b0, 32'h0000_0000, 32'hA5A5_0002};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_0014, 32'h0000_0000, 32'h0000_0000, 3, 32'h0000_0007, 1'b0, 32'h0000_0014, 1'b0, 32'h0000_0000, 32'h0000_0007};

    reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0; mem_rdata = 32'h0;
    exp_if_rd = 32'h0; exp_d_rd = 32'h0;
`ifdef ARB_TIMEOUT_EN
    t_d_req = 1'b0; t_d_addr = 32'h0; t_mem_ack = 1'b0;
`endif

    // Reset held for two edges, then released with no requests.
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst mem_req/we/acks/busy", {27'd0, mem_req, mem_we, if_ack, d_ack, busy}, 32'd0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst mem_wdata", mem_wdata, 32'h0);
    chk("rst if_rdata", if_rdata, 32'h0);
    chk("rst d_rdata", d_rdata, 32'h0);

    // Reset in the middle of a data grant abandons it without an ack.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0700; d_wdata = 32'h7777_7777;
    @(negedge clk);
    chk("midrst granted", {31'd0, mem_req}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst busy/acks", {29'd0, busy, if_ack, d_ack}, 32'd0);
    chk("midrst mem_addr", mem_addr, 32'h0);
    d_req = 1'b0; d_we = 1'b0; reset = 1'b1;
    @(negedge clk);
    chk("midrst after d_ack", {31'd0, d_ack}, 32'd0);
    chk("midrst after busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Stray mem_ack while idle must not create a completion.
    mem_ack = 1'b1; mem_rdata = 32'h9999_9999;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("stray%0d busy/acks/mem_req", c), {28'd0, busy, if_ack, d_ack, mem_req}, 32'd0);
      chk($sformatf("stray%0d if_rdata", c), if_rdata, exp_if_rd);
      chk($sformatf("stray%0d d_rdata", c), d_rdata, exp_d_rd);
    end
    mem_ack = 1'b0; mem_rdata = 32'h0;

`ifdef ARB_TIMEOUT_EN
    chk("main timeout_err", {31'd0, timeout_err}, 32'd0);
    // Memory never answers: four cycles of mem_req, then a DEADBEEF completion.
    t_d_req = 1'b1; t_d_addr = 32'h0000_0500;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("to wait%0d mem_req", c), {31'd0, t_mem_req}, 32'd1);
      chk($sformatf("to wait%0d mem_addr", c), t_mem_addr, 32'h0000_0500);
      chk($sformatf("to wait%0d d_ack", c), {31'd0, t_d_ack}, 32'd0);
    end
    @(negedge clk);
    t_d_req = 1'b0;
    chk("to expire mem_req", {31'd0, t_mem_req}, 32'd0);
    chk("to expire d_ack", {31'd0, t_d_ack}, 32'd1);
    chk("to expire d_rdata", t_d_rdata, 32'hDEAD_BEEF);
    chk("to expire err", {31'd0, t_timeout_err}, 32'd1);
    repeat (3) @(negedge clk);
    chk("to sticky err", {31'd0, t_timeout_err}, 32'd1);
    chk("to idle d_ack/busy", {30'd0, t_d_ack, t_busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("to err cleared", {31'd0, t_timeout_err}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_mem_port_arbiter

`default_nettype wire
